// File: rtl/bounded_step_counter_pkg.sv
// rtl/bounded_step_counter_pkg.sv - shared types, mode constants and parameter check
package bounded_step_counter_pkg;

  localparam logic CNT_MODE_SAT  = 1'b0;
  localparam logic CNT_MODE_WRAP = 1'b1;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_SET  = 2'd1,
    CMD_UP   = 2'd2,
    CMD_DOWN = 2'd3
  } cmd_e;

  // True when the bounds and reset value describe a usable counter.
  function automatic bit params_legal(input int width, input int min_v,
                                      input int max_v, input int rst_v);
    longint top_v;
    top_v = (longint'(1) << width) - 1;
    return (min_v >= 0) && (min_v < max_v) && (longint'(max_v) <= top_v) &&
           (rst_v >= min_v) && (rst_v <= max_v);
  endfunction

endpackage

// File: rtl/bounded_step_counter_if.sv
// rtl/bounded_step_counter_if.sv - command and status bundle for the step counter
interface bounded_step_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              up;
  logic              down;
  logic              set;
  logic              wrap;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;
  logic              at_max;
  logic              at_min;
  logic              ovf;
  logic              unf;
  logic              load_err;

  modport master (
    output en, up, down, set, wrap, step, in,
    input  out, at_max, at_min, ovf, unf, load_err
  );

  modport slave (
    input  en, up, down, set, wrap, step, in,
    output out, at_max, at_min, ovf, unf, load_err
  );
endinterface

// File: rtl/bounded_step_counter_step_wrap_calc.sv
// rtl/bounded_step_counter_step_wrap_calc.sv - next count for one up/down step
module step_wrap_calc
  import bounded_step_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MIN   = 0,
  parameter int MAX   = 255
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH:0]   s,
  input  logic             dir_up,
  input  logic             wrap,
  output logic [WIDTH-1:0] nxt,
  output logic             crossed
);
  // One extra bit holds MAX+R and R itself when the range spans 2**WIDTH.
  localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] RANGE = (WIDTH+1)'(MAX - MIN + 1);

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] floor_v;

  assign cur_x   = {1'b0, cur};
  assign sum     = cur_x + s;
  // Down-step underflow tested as cur < MIN+s so nothing ever goes negative.
  assign floor_v = MIN_X + s;

  // Step in the requested direction and fold or clamp at the crossed bound.
  always_comb begin
    nxt     = cur;
    crossed = 1'b0;
    if (dir_up) begin
      if (sum > MAX_X) begin
        crossed = 1'b1;
        if (wrap == CNT_MODE_SAT) nxt = MAX_X[WIDTH-1:0];
        else                      nxt = WIDTH'(sum - RANGE);
      end else begin
        nxt = WIDTH'(sum);
      end
    end else begin
      if (cur_x >= floor_v) begin
        nxt = WIDTH'(cur_x - s);
      end else begin
        crossed = 1'b1;
        if (wrap == CNT_MODE_WRAP) nxt = WIDTH'(cur_x + RANGE - s);
        else                       nxt = MIN_X[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/bounded_step_counter.sv
// rtl/bounded_step_counter.sv - bounded up/down/set counter with saturate or wrap
module bounded_step_counter
  import bounded_step_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int MIN     = 0,
  parameter int MAX     = 255,
  parameter int RST_VAL = 0
) (
  input logic clk,
  input logic rst,
  bounded_step_counter_if.slave bus
);
  localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] RANGE = (WIDTH+1)'(MAX - MIN + 1);

  if (!params_legal(WIDTH, MIN, MAX, RST_VAL)) begin : g_bad_params
    $error("bounded_step_counter: illegal WIDTH/MIN/MAX/RST_VAL");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             load_err_q, load_err_d;

  cmd_e             cmd;
  logic [WIDTH:0]   s_eff;
  logic [WIDTH:0]   in_x;
  logic [WIDTH-1:0] calc_nxt;
  logic             calc_crossed;

  // Decode the command: set wins, opposing up/down cancel out.
  always_comb begin
    cmd = CMD_HOLD;
    if (bus.set)                 cmd = CMD_SET;
    else if (bus.up && !bus.down) cmd = CMD_UP;
    else if (bus.down && !bus.up) cmd = CMD_DOWN;
  end

  // Effective step is capped at the range size so one wrap never laps twice.
  always_comb begin
    if (int'(bus.step) > int'(RANGE)) s_eff = RANGE;
    else                              s_eff = (WIDTH+1)'(bus.step);
  end

  assign in_x = {1'b0, bus.in};

  step_wrap_calc #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX)
  ) u_calc (
    .cur     (out_q),
    .s       (s_eff),
    .dir_up  (cmd == CMD_UP),
    .wrap    (bus.wrap),
    .nxt     (calc_nxt),
    .crossed (calc_crossed)
  );

  // Next count and event pulses; pulses default low so they last one cycle.
  always_comb begin
    out_d      = out_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    load_err_d = 1'b0;
    if (bus.en) begin
      case (cmd)
        CMD_SET: begin
          if (in_x < MIN_X) begin
            out_d      = MIN_X[WIDTH-1:0];
            load_err_d = 1'b1;
          end else if (in_x > MAX_X) begin
            out_d      = MAX_X[WIDTH-1:0];
            load_err_d = 1'b1;
          end else begin
            out_d = bus.in;
          end
        end
        CMD_UP: begin
          if (s_eff != '0) begin
            out_d = calc_nxt;
            ovf_d = calc_crossed;
          end
        end
        CMD_DOWN: begin
          if (s_eff != '0) begin
            out_d = calc_nxt;
            unf_d = calc_crossed;
          end
        end
        default: ;
      endcase
    end
  end

  // Count and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= WIDTH'(RST_VAL);
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.load_err = load_err_q;
  assign bus.at_max   = (out_q == MAX_X[WIDTH-1:0]);
  assign bus.at_min   = (out_q == MIN_X[WIDTH-1:0]);

endmodule

// File: tb/tb_bounded_step_counter.sv
// tb/tb_bounded_step_counter.sv - scoreboard bench for bounded_step_counter
module tb_bounded_step_counter;

  localparam int A_MIN = 10;
  localparam int A_MAX = 200;
  localparam int B_MIN = 10;
  localparam int B_MAX = 20;

  typedef struct {
    int out;
    bit ovf;
    bit unf;
    bit lerr;
    bit at_max;
    bit at_min;
  } exp_t;

  logic clk;
  logic rst;

  bounded_step_counter_if #(.WIDTH(8), .STEP_W(4)) a_if ();
  bounded_step_counter_if #(.WIDTH(8), .STEP_W(4)) b_if ();

  bounded_step_counter #(
    .WIDTH(8), .STEP_W(4), .MIN(A_MIN), .MAX(A_MAX), .RST_VAL(10)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  bounded_step_counter #(
    .WIDTH(8), .STEP_W(4), .MIN(B_MIN), .MAX(B_MAX), .RST_VAL(10)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_a    = 10;
  int   cnt_b    = 10;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int cur, input int mn, input int mx,
                                 input bit en, input bit up, input bit down,
                                 input bit set, input bit wrap, input int step,
                                 input int in_v);
    exp_t e;
    int   r;
    int   s;
    int   n;
    e = '{out: cur, ovf: 0, unf: 0, lerr: 0, at_max: 0, at_min: 0};
    r = mx - mn + 1;
    s = (step > r) ? r : step;
    if (!en) begin
      e.out = cur;
    end else if (set) begin
      if (in_v < mn)      begin e.out = mn; e.lerr = 1; end
      else if (in_v > mx) begin e.out = mx; e.lerr = 1; end
      else                e.out = in_v;
    end else if (up != down && s != 0) begin
      n = up ? cur + s : cur - s;
      if (n > mx) begin
        e.ovf = 1;
        e.out = wrap ? n - r : mx;
      end else if (n < mn) begin
        e.unf = 1;
        e.out = wrap ? n + r : mn;
      end else begin
        e.out = n;
      end
    end
    e.at_max = (e.out == mx);
    e.at_min = (e.out == mn);
    return e;
  endfunction

  task automatic idle_all();
    a_if.en = 0; a_if.up = 0; a_if.down = 0; a_if.set = 0; a_if.wrap = 0;
    a_if.step = '0; a_if.in = '0;
    b_if.en = 0; b_if.up = 0; b_if.down = 0; b_if.set = 0; b_if.wrap = 0;
    b_if.step = '0; b_if.in = '0;
  endtask

  // Drive one command to one counter, push its expectation, then compare.
  task automatic cmd(input bit sel_b, input bit en, input bit up, input bit down,
                     input bit set, input bit wrap, input int step, input int in_v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    idle_all();
    if (sel_b) begin
      b_if.en = en; b_if.up = up; b_if.down = down; b_if.set = set;
      b_if.wrap = wrap; b_if.step = 4'(step); b_if.in = 8'(in_v);
      e = model(cnt_b, B_MIN, B_MAX, en, up, down, set, wrap, step, in_v);
      cnt_b = e.out;
    end else begin
      a_if.en = en; a_if.up = up; a_if.down = down; a_if.set = set;
      a_if.wrap = wrap; a_if.step = 4'(step); a_if.in = 8'(in_v);
      e = model(cnt_a, A_MIN, A_MAX, en, up, down, set, wrap, step, in_v);
      cnt_a = e.out;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    if (sel_b) begin
      check("sb_b_out", b_if.out, g.out);
      check("sb_b_ovf", b_if.ovf, g.ovf);
      check("sb_b_unf", b_if.unf, g.unf);
      check("sb_b_lerr", b_if.load_err, g.lerr);
      check("sb_b_at_max", b_if.at_max, g.at_max);
      check("sb_b_at_min", b_if.at_min, g.at_min);
    end else begin
      check("sb_a_out", a_if.out, g.out);
      check("sb_a_ovf", a_if.ovf, g.ovf);
      check("sb_a_unf", a_if.unf, g.unf);
      check("sb_a_lerr", a_if.load_err, g.lerr);
      check("sb_a_at_max", a_if.at_max, g.at_max);
      check("sb_a_at_min", a_if.at_min, g.at_min);
    end
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", a_if.out, 10);
    check("rst_at_min", a_if.at_min, 1);
    check("rst_at_max", a_if.at_max, 0);
    check("rst_pulses", {a_if.ovf, a_if.unf, a_if.load_err}, 0);
    check("rst_b_out", b_if.out, 10);
    @(negedge clk);
    rst = 1'b0;

    // 1: asynchronous reset in the middle of a cycle
    cmd(0, 1, 0, 0, 1, 0, 0, 57);
    check("t1_pre_out", a_if.out, 57);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_out", a_if.out, 10);
    check("t1_rst_at_min", a_if.at_min, 1);
    check("t1_rst_pulses", {a_if.ovf, a_if.unf, a_if.load_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_a = 10;
    cnt_b = 10;

    // 2: saturate at MAX, repeated overflow, then pulse drops
    cmd(0, 1, 0, 0, 1, 0, 0, 198);
    cmd(0, 1, 1, 0, 0, 0, 5, 0);
    check("t2_out", a_if.out, 200);
    check("t2_ovf", a_if.ovf, 1);
    cmd(0, 1, 1, 0, 0, 0, 5, 0);
    check("t2_rep_out", a_if.out, 200);
    check("t2_rep_ovf", a_if.ovf, 1);
    cmd(0, 1, 0, 0, 0, 0, 5, 0);
    check("t2_ovf_clr", a_if.ovf, 0);

    // 3: wrap both directions
    cmd(0, 1, 0, 0, 1, 1, 0, 198);
    cmd(0, 1, 1, 0, 0, 1, 5, 0);
    check("t3_up_out", a_if.out, 12);
    check("t3_up_ovf", a_if.ovf, 1);
    cmd(0, 1, 0, 1, 0, 1, 5, 0);
    check("t3_dn_out", a_if.out, 198);
    check("t3_dn_unf", a_if.unf, 1);

    // 4: load clamping and set priority over up
    cmd(0, 1, 0, 0, 1, 0, 0, 250);
    check("t4_hi_out", a_if.out, 200);
    check("t4_hi_lerr", a_if.load_err, 1);
    cmd(0, 1, 0, 0, 1, 0, 0, 3);
    check("t4_lo_out", a_if.out, 10);
    check("t4_lo_lerr", a_if.load_err, 1);
    cmd(0, 1, 1, 0, 1, 0, 15, 77);
    check("t4_setup_out", a_if.out, 77);
    check("t4_setup_ovf", a_if.ovf, 0);

    // 5: up+down cancels; en=0 holds and clears a pending pulse
    cmd(0, 1, 0, 0, 1, 0, 0, 50);
    cmd(0, 1, 1, 1, 0, 0, 3, 0);
    check("t5_updn_out", a_if.out, 50);
    cmd(0, 1, 0, 0, 1, 0, 0, 250);
    cmd(0, 0, 1, 0, 0, 0, 5, 0);
    check("t5_en0_out", a_if.out, 200);
    check("t5_en0_pulses", {a_if.ovf, a_if.unf, a_if.load_err}, 0);

    // 6: step capped at range on the narrow counter; zero step holds
    cmd(1, 1, 0, 0, 1, 1, 0, 15);
    cmd(1, 1, 1, 0, 0, 1, 15, 0);
    check("t6_cap_out", b_if.out, 15);
    check("t6_cap_ovf", b_if.ovf, 1);
    cmd(1, 1, 1, 0, 0, 1, 0, 0);
    check("t6_zero_out", b_if.out, 15);
    check("t6_zero_ovf", b_if.ovf, 0);
    cmd(1, 1, 0, 1, 0, 0, 9, 0);
    check("t6_sat_dn_out", b_if.out, 10);
    check("t6_sat_dn_unf", b_if.unf, 1);

    // Random mix against the model on both counters
    for (int i = 0; i < 300; i++) begin
      cmd(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
